// File: rtl/sign_extend_unit.sv
// Immediate extension stage: widens an IN_W immediate to OUT_W with
// combinational and registered results.
module sign_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             out_valid
);

    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] upper;
    logic [OUT_W-1:0] sext_sh2;
    logic [OUT_W-1:0] out_d;
    logic             valid_q;
    logic             valid_d;

    assign sext     = {{EXT_W{in[IN_W-1]}}, in};
    assign zext     = {{EXT_W{1'b0}}, in};
    // Shifting the zero-extended value also covers OUT_W < 2*IN_W,
    // where high immediate bits fall off the top.
    assign upper    = zext << EXT_W;
    assign sext_sh2 = sext << 2;

    always_comb begin
        out = sext;
        unique case (mode)
            2'b00: out = sext;
            2'b01: out = zext;
            2'b10: out = upper;
            2'b11: out = sext_sh2;
            default: out = sext;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        if (in_valid) begin
            out_d   = out;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;

endmodule

// File: tb/tb_sign_extend_unit.sv
// Randomized and directed checks of sign_extend_unit against an
// arithmetic reference model.
module tb_sign_extend_unit;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic [1:0]  mode;
    logic        in_valid;
    logic [31:0] out;
    logic [31:0] out_q;
    logic        out_valid;

    int total;
    int bad;

    logic [31:0] exp_q;
    logic        exp_v;

    sign_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .mode      (mode),
        .in_valid  (in_valid),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input int m, input int v);
        longint s;
        longint r;
        s = (v >= 32768) ? longint'(v) - 65536 : longint'(v);
        case (m)
            0:       r = s;
            1:       r = v;
            2:       r = longint'(v) * 65536;
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    task automatic apply(input int m, input int v, input bit vld,
                         input bit r);
        logic [31:0] e;
        @(negedge clk);
        mode     = m[1:0];
        in       = v[15:0];
        in_valid = vld;
        rst      = r;
        #1;
        e = ref_ext(m, v);
        chk("out", out, e);
        if (r) begin
            exp_q = 32'h0;
            exp_v = 1'b0;
        end else if (vld) begin
            exp_q = e;
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_q", out_q, exp_q);
        chk("out_valid", {31'h0, out_valid}, {31'h0, exp_v});
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in       = 16'h0;
        mode     = 2'b00;
        in_valid = 1'b1;
        exp_q    = 32'h0;
        exp_v    = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_q", out_q, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);

        apply(0, 'h00FF, 1, 1);
        chk("lit_00ff", out, 32'h0000_00FF);
        apply(0, 'h00FF, 1, 0);
        chk("lit_00ff_q", out_q, 32'h0000_00FF);
        apply(0, 'h8000, 1, 0);
        chk("lit_8000", out, 32'hFFFF_8000);
        apply(0, 'h7FFF, 1, 0);
        chk("lit_7fff", out, 32'h0000_7FFF);
        apply(0, 'hFFFF, 1, 0);
        chk("lit_ffff", out, 32'hFFFF_FFFF);
        apply(1, 'h8000, 1, 0);
        chk("lit_z8000", out, 32'h0000_8000);
        apply(2, 'h1234, 1, 0);
        chk("lit_up1234", out, 32'h1234_0000);
        apply(3, 'hFFFF, 1, 0);
        chk("lit_sh_ffff", out, 32'hFFFF_FFFC);
        apply(3, 'h0001, 1, 0);
        chk("lit_sh_0001", out, 32'h0000_0004);
        apply(0, 'h1234, 1, 1);
        apply(1, 'hABCD, 1, 0);
        apply(2, 'h5555, 0, 0);
        apply(3, 'h7777, 0, 0);
        chk("hold_q", out_q, 32'h0000_ABCD);

        for (int i = 0; i < 300; i++) begin
            apply(int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 65535)),
                  bit'($urandom_range(0, 3) != 0),
                  bit'($urandom_range(0, 24) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
